// File: rtl/scope_pkg.sv
// Shared definitions for the oscilloscope capture block: FSM states,
// trigger-mode encodings and the trigger decision helper.
package scope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [1:0] TRIG_RISE = 2'b00;
  localparam logic [1:0] TRIG_FALL = 2'b01;
  localparam logic [1:0] TRIG_BOTH = 2'b10;
  localparam logic [1:0] TRIG_IMM  = 2'b11;

  // Edge modes only fire when a previous sample of this capture exists.
  function automatic logic trig_hit(input logic [1:0] mode, input logic prev_ok,
                                    input logic prev_below, input logic cur_below);
    logic rise;
    logic fall;
    rise = prev_ok && prev_below && !cur_below;
    fall = prev_ok && !prev_below && cur_below;
    case (mode)
      TRIG_RISE: trig_hit = rise;
      TRIG_FALL: trig_hit = fall;
      TRIG_BOTH: trig_hit = rise || fall;
      default:   trig_hit = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/scope_capture_ram.sv
// Sample store: one write port and one registered read port, contents never reset.
module scope_capture_ram #(
  parameter int SAMPLE_W = 8,
  parameter int DEPTH    = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [SAMPLE_W-1:0]      wr_data,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [SAMPLE_W-1:0]      rd_data
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/scope_capture.sv
// Triggered capture engine for an ADC stream: a ring buffer keeps PRETRIG
// samples ahead of the trigger and fills the rest of the record after it.
module scope_capture
  import scope_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int DEPTH    = 64,
  parameter int PRETRIG  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     sample_valid,
  input  logic [SAMPLE_W-1:0]      sample_in,
  input  logic                     arm,
  input  logic [1:0]               trig_mode,
  input  logic [SAMPLE_W-1:0]      trig_level,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [SAMPLE_W-1:0]      rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] start_ptr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PRE_CNT  = CW'(PRETRIG);
  localparam logic [CW-1:0] POST_CNT = CW'(DEPTH - PRETRIG);
  localparam logic [AW-1:0] PRE_OFS  = AW'(PRETRIG);

  state_t              state;
  logic [AW-1:0]       wr_ptr;
  logic [CW-1:0]       cnt;
  logic [SAMPLE_W-1:0] prev;
  logic                prev_ok;
  logic                rd_live;
  logic                capturing;
  logic                take;
  logic                eval_trig;
  logic                trig_fire;
  logic [AW-1:0]       rd_phys;
  logic [SAMPLE_W-1:0] ram_q;

  assign capturing = (state == ST_PREFILL) || (state == ST_ARMED) || (state == ST_POST);
  assign take      = ena && sample_valid && !arm && capturing;
  // With no pre-trigger window the very first sample is already a trigger candidate.
  assign eval_trig = (state == ST_ARMED) || ((state == ST_PREFILL) && (PRETRIG == 0));
  assign trig_fire = take && eval_trig &&
                     trig_hit(trig_mode, prev_ok, prev < trig_level, sample_in < trig_level);

  assign busy    = capturing;
  assign done    = (state == ST_DONE);
  assign rd_phys = start_ptr + rd_addr;
  assign rd_data = rd_live ? ram_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      cnt       <= '0;
      prev      <= '0;
      prev_ok   <= 1'b0;
      start_ptr <= '0;
      rd_live   <= 1'b0;
    end else if (ena) begin
      rd_live <= 1'b1;
      if (arm) begin
        state   <= ST_PREFILL;
        wr_ptr  <= '0;
        cnt     <= '0;
        prev_ok <= 1'b0;
      end else if (take) begin
        wr_ptr  <= wr_ptr + 1'b1;
        prev    <= sample_in;
        prev_ok <= 1'b1;
        if (trig_fire) begin
          start_ptr <= wr_ptr - PRE_OFS;
          cnt       <= CW'(1);
          state     <= (POST_CNT == CW'(1)) ? ST_DONE : ST_POST;
        end else begin
          case (state)
            ST_PREFILL: begin
              if ((PRETRIG == 0) || (cnt + 1'b1 == PRE_CNT)) begin
                state <= ST_ARMED;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            ST_POST: begin
              cnt <= cnt + 1'b1;
              if (cnt + 1'b1 == POST_CNT) begin
                state <= ST_DONE;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  scope_capture_ram #(
    .SAMPLE_W(SAMPLE_W),
    .DEPTH   (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (take),
    .wr_addr(wr_ptr),
    .wr_data(sample_in),
    .re     (ena),
    .rd_addr(rd_phys),
    .rd_data(ram_q)
  );

endmodule

// File: tb/tb_scope_capture.sv
// Bench for scope_capture: a default-sized instance and a DEPTH=8/PRETRIG=0 instance
// share stimulus and are compared against a sample-history model of the capture rules.
module tb_scope_capture;

  localparam int DA = 64;
  localparam int PA = 16;
  localparam int DB = 8;
  localparam int PB = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       sample_valid;
  logic       arm;
  logic [7:0] sample_in;
  logic [7:0] trig_level;
  logic [1:0] trig_mode;
  logic [5:0] rd_addr_a;
  logic [5:0] start_a;
  logic [2:0] rd_addr_b;
  logic [2:0] start_b;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic       busy_a, done_a, busy_b, done_b;

  int checks = 0;
  int failures = 0;
  int hist[$];
  bit capturing = 1'b0;
  int ramp_v = 0;

  always #5 clk = ~clk;

  scope_capture #(.SAMPLE_W(8), .DEPTH(DA), .PRETRIG(PA)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_valid(sample_valid), .sample_in(sample_in),
    .arm(arm), .trig_mode(trig_mode), .trig_level(trig_level), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .busy(busy_a), .done(done_a), .start_ptr(start_a)
  );

  scope_capture #(.SAMPLE_W(8), .DEPTH(DB), .PRETRIG(PB)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_valid(sample_valid), .sample_in(sample_in),
    .arm(arm), .trig_mode(trig_mode), .trig_level(trig_level), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .busy(busy_b), .done(done_b), .start_ptr(start_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // First history index that satisfies the trigger rule, searching from the end of the pre-trigger window.
  function automatic int find_trig(input int pre);
    int lvl;
    bit rise;
    bit fall;
    lvl = int'(trig_level);
    for (int n = pre; n < hist.size(); n++) begin
      if (trig_mode == 2'b11) return n;
      if (n > 0) begin
        rise = (hist[n-1] < lvl) && (hist[n] >= lvl);
        fall = (hist[n-1] >= lvl) && (hist[n] < lvl);
        if ((trig_mode == 2'b00 && rise) || (trig_mode == 2'b01 && fall) ||
            (trig_mode == 2'b10 && (rise || fall))) return n;
      end
    end
    return -1;
  endfunction

  // 0 = idle, 1 = capture running, 2 = record complete.
  function automatic int exp_state(input int pre, input int depth);
    int t;
    if (!capturing) return 0;
    t = find_trig(pre);
    if (t >= 0 && hist.size() >= t + depth - pre) return 2;
    return 1;
  endfunction

  task automatic check_status(input string tag);
    int sa;
    int sb;
    sa = exp_state(PA, DA);
    sb = exp_state(PB, DB);
    checkOutput({tag, "_busy_a"}, busy_a, 32'(sa == 1));
    checkOutput({tag, "_done_a"}, done_a, 32'(sa == 2));
    checkOutput({tag, "_busy_b"}, busy_b, 32'(sb == 1));
    checkOutput({tag, "_done_b"}, done_b, 32'(sb == 2));
  endtask

  // Drive one cycle from a falling edge, update the model, check status on the next falling edge.
  task automatic applyStimulus(input bit valid, input int value, input bit armv, input bit enav,
                               input string tag);
    sample_valid = valid;
    sample_in    = 8'(value);
    arm          = armv;
    ena          = enav;
    if (enav && armv) begin
      hist.delete();
      capturing = 1'b1;
    end else if (enav && valid && capturing) begin
      hist.push_back(value & 255);
    end
    @(negedge clk);
    arm          = 1'b0;
    sample_valid = 1'b0;
    ena          = 1'b1;
    check_status(tag);
  endtask

  task automatic arm_capture(input int mode, input int lvl, input string tag);
    trig_mode  = 2'(mode);
    trig_level = 8'(lvl);
    applyStimulus(1'b0, 0, 1'b1, 1'b1, tag);
  endtask

  task automatic feed_ramp(input int step, input int n_max, input string tag);
    for (int k = 0; k < n_max; k++) begin
      if (exp_state(PA, DA) == 2 && exp_state(PB, DB) == 2) break;
      applyStimulus(1'b1, ramp_v, 1'b0, 1'b1, tag);
      ramp_v = (ramp_v + step) & 255;
    end
  endtask

  task automatic check_record(input string tag);
    int ta;
    int tb;
    int n;
    bit a_done;
    bit b_done;
    a_done = (exp_state(PA, DA) == 2);
    b_done = (exp_state(PB, DB) == 2);
    ta = find_trig(PA);
    tb = find_trig(PB);
    if (a_done) checkOutput({tag, "_start_a"}, start_a, 32'((ta - PA) % DA));
    if (b_done) checkOutput({tag, "_start_b"}, start_b, 32'((tb - PB) % DB));
    n = a_done ? DA : (b_done ? DB : 0);
    for (int i = 0; i < n; i++) begin
      rd_addr_a = 6'(i);
      rd_addr_b = 3'(i % DB);
      applyStimulus(1'b0, 0, 1'b0, 1'b1, {tag, "_rd"});
      if (a_done) checkOutput($sformatf("%s_rd_a%0d", tag, i), rd_data_a, 32'(hist[ta - PA + i]));
      if (b_done && i < DB) checkOutput($sformatf("%s_rd_b%0d", tag, i), rd_data_b, 32'(hist[tb - PB + i]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  v;
    bit  va;
    bit  en;
    bit  ar;

    rst_n = 1'b0; ena = 1'b1; sample_valid = 1'b0; arm = 1'b0; sample_in = '0;
    trig_mode = 2'b00; trig_level = 8'd100; rd_addr_a = '0; rd_addr_b = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_busy_a", busy_a, 0);
    checkOutput("rst_done_a", done_a, 0);
    checkOutput("rst_start_a", start_a, 0);
    checkOutput("rst_rd_a", rd_data_a, 0);
    checkOutput("rst_busy_b", busy_b, 0);
    checkOutput("rst_rd_b", rd_data_b, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b1, "idle");

    $display("[TB] rising ramp, level 100");
    arm_capture(0, 100, "r33");
    ramp_v = 0;
    feed_ramp(1, 400, "r33");
    checkOutput("r33_done", done_a, 1);
    checkOutput("r33_start_const", start_a, 20);
    check_record("r33");

    $display("[TB] falling ramp, level 50");
    arm_capture(1, 50, "r34");
    ramp_v = 255;
    feed_ramp(-1, 400, "r34");
    checkOutput("r34_done", done_a, 1);
    checkOutput("r34_start_const", start_a, 62);
    check_record("r34");

    $display("[TB] crossing only inside the pre-trigger window");
    arm_capture(0, 5, "r35");
    ramp_v = 0;
    feed_ramp(1, 16, "r35");
    for (int k = 0; k < 1000; k++) applyStimulus(1'b1, 20, 1'b0, 1'b1, "r35_hold");
    checkOutput("r35_busy", busy_a, 1);
    checkOutput("r35_done", done_a, 0);
    check_record("r35");

    $display("[TB] immediate mode with valid gaps");
    arm_capture(3, 0, "r36");
    for (int k = 0; k < 400; k++) begin
      if (exp_state(PA, DA) == 2 && exp_state(PB, DB) == 2) break;
      applyStimulus($urandom_range(0, 2) != 0, int'($urandom_range(0, 255)), 1'b0, 1'b1, "r36");
    end
    checkOutput("r36_done_b", done_b, 1);
    checkOutput("r36_start_b_const", start_b, 0);
    check_record("r36");

    $display("[TB] re-arm during post-trigger fill");
    arm_capture(0, 100, "r37a");
    ramp_v = 0;
    feed_ramp(1, 120, "r37a");
    applyStimulus(1'b1, ramp_v, 1'b1, 1'b1, "r37a_rearm");
    ramp_v = (ramp_v + 1) & 255;
    checkOutput("r37a_rearm_done", done_a, 0);
    checkOutput("r37a_rearm_busy", busy_a, 1);
    feed_ramp(1, 600, "r37a");
    checkOutput("r37a_done", done_a, 1);
    check_record("r37a");

    $display("[TB] reset while armed");
    arm_capture(0, 100, "r37b");
    ramp_v = 0;
    feed_ramp(1, 30, "r37b");
    #2;
    rst_n = 1'b0;
    capturing = 1'b0;
    hist.delete();
    #1;
    checkOutput("r37b_rst_busy_a", busy_a, 0);
    checkOutput("r37b_rst_done_a", done_a, 0);
    checkOutput("r37b_rst_start_a", start_a, 0);
    checkOutput("r37b_rst_rd_a", rd_data_a, 0);
    checkOutput("r37b_rst_busy_b", busy_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    arm_capture(0, 100, "r37c");
    ramp_v = 0;
    feed_ramp(1, 400, "r37c");
    checkOutput("r37c_done", done_a, 1);
    checkOutput("r37c_start_const", start_a, 20);
    check_record("r37c");

    $display("[TB] enable dropped during post-trigger fill");
    arm_capture(0, 100, "r38");
    ramp_v = 0;
    feed_ramp(1, 110, "r38");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, ramp_v, 1'b0, 1'b0, "r38_hold");
      ramp_v = (ramp_v + 1) & 255;
    end
    checkOutput("r38_hold_start", start_a, 20);
    feed_ramp(1, 400, "r38");
    checkOutput("r38_done", done_a, 1);
    check_record("r38");

    $display("[TB] randomized captures");
    for (int it = 0; it < 12; it++) begin
      v = int'($urandom_range(0, 255));
      arm_capture(int'($urandom_range(0, 3)), int'($urandom_range(10, 245)), "rnd");
      for (int k = 0; k < 700; k++) begin
        if (exp_state(PA, DA) == 2 && exp_state(PB, DB) == 2) break;
        va = ($urandom_range(0, 3) != 0);
        en = ($urandom_range(0, 9) != 0);
        ar = ($urandom_range(0, 399) == 0);
        if (it % 2 == 1) begin
          v = int'($urandom_range(0, 255));
        end else begin
          v = v + int'($urandom_range(0, 60)) - 30;
          if (v < 0) v = 0;
          if (v > 255) v = 255;
        end
        applyStimulus(va, v, ar, en, "rnd");
      end
      check_record($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/scope_capture.md
SCOPE_CAPTURE -- requirements
Module: scope_capture

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 8, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, record length in samples; power of two, at least 8.
REQ-003 SHALL have parameter PRETRIG, default 16, samples kept before the trigger; range 0..DEPTH-1.
REQ-004 Port: clk  in  1  single design clock; all logic on the rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port: ena  in  1  tile enable; when low, the block holds all state and ignores all inputs except rst_n.
REQ-007 Port: sample_valid  in  1  qualifies sample_in for one cycle.
REQ-008 Port: sample_in  in  SAMPLE_W  unsigned ADC sample.
REQ-009 Port: arm  in  1  single-cycle pulse that starts a capture.
REQ-010 Port: trig_mode  in  2  trigger mode: 00 rising, 01 falling, 10 either edge, 11 immediate.
REQ-011 Port: trig_level  in  SAMPLE_W  unsigned threshold.
REQ-012 Port: rd_addr  in  log2(DEPTH)  logical read index, 0 = oldest sample of the record.
REQ-013 Port: rd_data  out  SAMPLE_W  registered read data.
REQ-014 Port: busy  out  1  high in PREFILL, ARMED and POST.
REQ-015 Port: done  out  1  high in DONE.
REQ-016 Port: start_ptr  out  log2(DEPTH)  physical address of logical index 0.

Function
REQ-017 SHALL implement states IDLE, PREFILL, ARMED, POST and DONE.
REQ-018 IDLE/DONE + arm -> PREFILL; write pointer, fill counter and prev-sample valid flag cleared.
REQ-019 Each accepted sample (ena and sample_valid) in PREFILL/ARMED/POST SHALL be written at the write pointer, which then increments modulo DEPTH (wrap).
REQ-020 PREFILL -> ARMED once PRETRIG samples are written; PRETRIG = 0 -> ARMED on the first accepted sample, evaluated as in REQ-021.
REQ-021 Trigger condition, ARMED only: rising = prev < level and cur >= level; falling = prev >= level and cur < level; either = rising or falling; immediate = first accepted sample in ARMED.
REQ-022 Edge modes SHALL need a valid prev (a sample accepted earlier in this capture, PREFILL included); prev updates on every accepted sample.
REQ-023 Triggering sample is written and counts as post-sample 1; trig address minus PRETRIG (mod DEPTH) latched into start_ptr; ARMED -> POST.
REQ-024 POST -> DONE after DEPTH-PRETRIG post-samples (trigger sample included); no writes in DONE or IDLE.
REQ-025 arm in PREFILL/ARMED/POST SHALL restart capture (as REQ-018); arm with a sample in the same cycle: restart wins, that sample is discarded.
REQ-026 Samples in ARMED are written without a trigger; older pre-trigger data overwritten by wrap.
REQ-027 rd_data = mem[(start_ptr + rd_addr) mod DEPTH], one-cycle latency; valid in any state, meaningful in DONE.
REQ-028 Comparisons SHALL be unsigned; pointer arithmetic modulo DEPTH without overflow flags.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, start_ptr=0, rd_data=0, pointers/counters/prev cleared; memory contents not reset.
REQ-030 Reset mid-capture SHALL abandon the record; post-reset arm behaves as first capture.

Structure
REQ-031 Shared package scope_pkg SHALL hold the state enum and trig_mode encodings (TRIG_RISE, TRIG_FALL, TRIG_BOTH, TRIG_IMM).
REQ-032 Sample storage SHALL be sub-module scope_capture_ram (1 write port, 1 registered read port, DEPTH x SAMPLE_W, no reset).

Verification
REQ-033 Defaults, ramp 0..255 each cycle, level 100, rising, arm -> trigger at sample 100; DONE after 48 post-samples; rd_addr 0 -> 84, rd_addr 16 -> 100, rd_addr 63 -> 147.
REQ-034 Falling, level 50, ramp 255 down -> trigger on sample value 49; rd_addr 16 -> 49.
REQ-035 Ramp crossing level during PREFILL (sample 5 of 16) -> no trigger until a later crossing; with no later crossing, busy stays 1 and done 0 for 1000 cycles.
REQ-036 Immediate mode, PRETRIG=0, DEPTH=8 -> done after 8 samples, start_ptr = address of first sample; sample_valid low gaps don't count.
REQ-037 arm pulse mid-POST -> PREFILL restart, done 0; rst_n low mid-ARMED -> IDLE next edge-free instant, busy 0.
REQ-038 ena low for 10 cycles mid-POST with sample_valid high -> post-count and pointers unchanged, capture completes after resuming.
